booth_issue_ctrl: RTL
=====================

Name: booth_issue_ctrl

Overview:
- Upstream/downstream wrapper for the 32-bit sequential radix-2 Booth multiplier (done-flag interface, restarted by its reset).
- Accepts tagged operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues one operation at a time by pulsing the multiplier's reset and holding its operands stable until its done flag rises.
- Captures each 64-bit product and returns it with its tag on a valid/ready output stream.

Parameters:
- W, 32, operand width; the product is 2*W.
- DEPTH, 4, operand FIFO entries; must be a power of 2, at least 2.
- TAG_W, 4, width of the user tag carried with each operation.
- TIMEOUT, 40, RUN-state cycle limit; used only with BOOTH_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operand pair offered
- in_ready  out  1  FIFO can accept
- in_M  in  W  multiplicand (signed)
- in_m  in  W  multiplier (signed)
- in_tag  in  TAG_W  user tag
- mul_rst  out  1  reset/start to the multiplier
- mul_M  out  W  multiplicand to the multiplier
- mul_m  out  W  multiplier operand to the multiplier
- mul_result  in  2W  product from the multiplier
- mul_done  in  1  multiplier done flag; level, stays high until mul_rst
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_result  out  2W  signed product
- out_tag  out  TAG_W  tag of the result
- out_err  out  1  result is a timeout result; tied 0 without the macro
- busy  out  1  FIFO non-empty, operation in flight, or result pending

Behaviour:
- Reset values: FIFO empty, state IDLE.
  - in_ready=0 during rst, 1 in the first cycle after rst.
  - mul_rst=1; mul_M=0, mul_m=0.
  - out_valid=0, out_result=0, out_tag=0, out_err=0, busy=0.
- Input side:
  - Push when in_valid && in_ready.
  - in_ready = !fifo_full, registered, no combinational path from out_ready or pop.
  - A push and a pop in the same cycle are legal when the FIFO is not full; the count is unchanged.
- States:
  - IDLE: mul_rst=1. If FIFO not empty, pop the head into registers op_M/op_m/op_tag and go to LAUNCH.
  - LAUNCH: one cycle, mul_rst=1, mul_M/mul_m driven from op regs; go to RUN.
  - RUN: mul_rst=0; mul_M/mul_m held constant, because the multiplier samples M on every step. On mul_done=1:
    - If the output register is empty, or is being drained this cycle (out_valid && out_ready), load mul_result/op_tag into it, set out_valid, and go to IDLE.
    - Otherwise go to WAIT_OUT.
  - WAIT_OUT: mul_rst=0; the multiplier holds its result. When the output register frees, load it and go to IDLE.
- The output register is single-entry; out_valid stays high, with stable data, until out_ready.
- Latency:
  - mul_done to out_valid is 1 cycle when the output register is free.
  - FIFO-head pop to mul_rst deassert is 2 cycles (IDLE, LAUNCH).
- Product: mul_result is passed through unmodified as the signed 2W product. The controller does no arithmetic.
- Ordering: results leave in strict issue order; there is one operation in flight at a time.
- Reset mid-operation:
  - Any state returns to IDLE, the FIFO is flushed, and a pending result is dropped (out_valid=0).
  - mul_rst is asserted the same cycle.
- mul_done while not in RUN/WAIT_OUT is ignored.
- FIFO pointers are log2(DEPTH)+1 bits; full/empty come from the MSB compare; wrap-around is natural.

Optional Feature:
- Macro: BOOTH_TIMEOUT_EN.
- With the macro:
  - A cycle counter clears in LAUNCH and increments in RUN.
  - If the counter reaches TIMEOUT without mul_done, the result is {2W{0}} with out_err=1 and the original tag, loaded through the same output-register rules. The state then returns to IDLE, which re-asserts mul_rst.
- Without the macro: no counter, out_err is constant 0, and RUN waits indefinitely.

Decomposition:
- Package booth_pkg: state encoding (IDLE, LAUNCH, RUN, WAIT_OUT), default width constants, TIMEOUT default.
- Sub-module booth_op_fifo: synchronous FIFO, width 2W+TAG_W, DEPTH entries, registered full/empty.

Test Plan:
- Single op: M=7, m=8, tag=3 → out_result=56, out_tag=3, out_err=0; mul_M/mul_m stable throughout RUN.
- Signed: M=-3, m=5 → 64'hFFFF_FFFF_FFFF_FFF1. Then M=-6, m=-7 → 42; results arrive in issue order.
- Backpressure: 6 pushes with out_ready=0 → in_ready drops after 4 buffered plus 1 in flight.
  - Releasing out_ready drains all products in order with tags 0..5.
  - No result is lost while WAIT_OUT is held.
- Reset mid-RUN: rst asserted 10 cycles into an op → next cycle out_valid=0, busy=0, mul_rst=1, in_ready=1; the next op (2×3) gives 6.
- Simultaneous push/pop: push each cycle while draining → FIFO count stays constant; no duplicated or dropped tags.
- BOOTH_TIMEOUT_EN with the multiplier model stalled (mul_done held 0) → after 40 RUN cycles, out_valid=1, out_err=1, out_result=0; the following op completes normally.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and default sizing for the Booth multiplier issue controller.
package booth_pkg;

    localparam int unsigned W_DEFAULT       = 32;
    localparam int unsigned DEPTH_DEFAULT   = 4;
    localparam int unsigned TAG_W_DEFAULT   = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 40;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LAUNCH   = 2'd1,
        ST_RUN      = 2'd2,
        ST_WAIT_OUT = 2'd3
    } state_e;

endpackage

// File: rtl/booth_op_fifo.sv
// Synchronous operand FIFO with registered full/empty derived from
// extended (MSB-wrap) read/write pointers.
module booth_op_fifo
    import booth_pkg::*;
#(
    parameter int unsigned DW    = 2 * W_DEFAULT + TAG_W_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push_ok, pop_ok;

    always_comb begin
        push_ok  = push && !full_q;
        pop_ok   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        // Flags are computed from the next pointers so they can be registered.
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/booth_issue_ctrl.sv
// Issue/retire wrapper around a sequential radix-2 Booth multiplier.
// Optional RUN-state watchdog enabled by defining BOOTH_TIMEOUT_EN.
module booth_issue_ctrl
    import booth_pkg::*;
#(
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned TAG_W = TAG_W_DEFAULT
`ifdef BOOTH_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_M,
    input  logic [W-1:0]     in_m,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mul_rst,
    output logic [W-1:0]     mul_M,
    output logic [W-1:0]     mul_m,
    input  logic [2*W-1:0]   mul_result,
    input  logic             mul_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);

    localparam int unsigned DW = 2 * W + TAG_W;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DW-1:0] fifo_rdata;

    state_e           state_q, state_d;
    logic [W-1:0]     op_M_q, op_M_d, op_m_q, op_m_d;
    logic [TAG_W-1:0] op_tag_q, op_tag_d;
    logic             out_valid_q, out_valid_d;
    logic [2*W-1:0]   out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_free, run_done, res_err;

`ifdef BOOTH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_pend_q, err_pend_d;
    logic             out_err_q, out_err_d;
`endif

    assign in_ready  = !fifo_full && !rst;
    assign fifo_push = in_valid && in_ready;

    booth_op_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({in_M, in_m, in_tag}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        op_M_d       = op_M_q;
        op_m_d       = op_m_q;
        op_tag_d     = op_tag_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        out_free     = !out_valid_q || out_ready;
        fifo_pop     = 1'b0;
        run_done     = 1'b0;
        res_err      = 1'b0;
`ifdef BOOTH_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_pend_d   = err_pend_q;
        out_err_d    = out_err_q && !out_ready;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop                     = 1'b1;
                    {op_M_d, op_m_d, op_tag_d}   = fifo_rdata;
                    state_d                      = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_RUN;
`ifdef BOOTH_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_RUN: begin
                run_done = mul_done;
`ifdef BOOTH_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
                if (!mul_done && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    run_done = 1'b1;
                    res_err  = 1'b1;
                end
                err_pend_d = res_err;
`endif
                if (run_done) begin
                    state_d = ST_WAIT_OUT;
                end
            end
            ST_WAIT_OUT: begin
                // The multiplier holds its result here, so retiring simply waits for the slot.
                run_done = 1'b1;
`ifdef BOOTH_TIMEOUT_EN
                res_err  = err_pend_q;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (run_done && out_free) begin
            out_valid_d  = 1'b1;
            out_result_d = res_err ? '0 : mul_result;
            out_tag_d    = op_tag_q;
            state_d      = ST_IDLE;
`ifdef BOOTH_TIMEOUT_EN
            out_err_d    = res_err;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_M_q       <= '0;
            op_m_q       <= '0;
            op_tag_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
`ifdef BOOTH_TIMEOUT_EN
            cnt_q        <= '0;
            err_pend_q   <= 1'b0;
            out_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            op_M_q       <= op_M_d;
            op_m_q       <= op_m_d;
            op_tag_q     <= op_tag_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
`ifdef BOOTH_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_pend_q   <= err_pend_d;
            out_err_q    <= out_err_d;
`endif
        end
    end

    assign mul_rst    = rst || (state_q == ST_IDLE) || (state_q == ST_LAUNCH);
    assign mul_M      = op_M_q;
    assign mul_m      = op_m_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign busy       = !fifo_empty || (state_q != ST_IDLE) || out_valid_q;
`ifdef BOOTH_TIMEOUT_EN
    assign out_err    = out_err_q;
`else
    assign out_err    = 1'b0;
`endif

endmodule
